// File: rtl/branch_flush_ctrl.sv
// Branch resolution and flush control.
// Resolves up to LANES branches per cycle, picks the lowest-index taken lane,
// redirects the fetch pc and pulses flush_en. It also tracks outstanding
// branches and forwards the flush through a FLUSH_DLY-deep delay line to the buffer.
module branch_flush_ctrl #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BID_W     = 3,
  parameter int FETCH_W   = 2,
  parameter int FLUSH_DLY = 1,
  parameter int MAX_BR    = 2**BID_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FETCH_W-1:0]        fetch_vld,
  input  logic                      br_dispatch,
  input  logic                      iq_full,
  input  logic                      buffer_full,
  input  logic [LANES*4-1:0]        lane_op,
  input  logic [LANES*DATA_W-1:0]   lane_data1,
  input  logic [LANES*DATA_W-1:0]   lane_data2,
  input  logic [LANES*BID_W-1:0]    lane_bid,
  input  logic [LANES*ADDR_W-1:0]   lane_addr,
  output logic [ADDR_W-1:0]         pc,
  output logic                      bid_full,
  output logic                      flush_en,
  output logic [BID_W-1:0]          flush_bid,
  output logic                      buffer_flush_en,
  output logic [BID_W-1:0]          buffer_flush_bid
);

  localparam int CNT_W = $clog2(MAX_BR + 1);
  localparam int RET_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + RET_W + 1;

  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;

  logic                 taken;
  logic [BID_W-1:0]     win_bid;
  logic [ADDR_W-1:0]    win_addr;
  logic [RET_W-1:0]     retire;
  logic [ADDR_W-1:0]    adv;
  logic                 stall;
  logic                 dispatch_ok;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [SUM_W-1:0]     up;
  logic [SUM_W-1:0]     dn;

  logic [FLUSH_DLY-1:0] dly_en;
  logic [BID_W-1:0]     dly_bid [FLUSH_DLY];

  // Resolve lanes: lowest-index taken lane wins, not-taken lanes retire; wrong-path lanes during a flush are ignored
  always_comb begin
    logic [3:0] op;
    logic       eq;
    logic       hit;
    taken    = 1'b0;
    win_bid  = '0;
    win_addr = '0;
    retire   = '0;
    op       = '0;
    eq       = 1'b0;
    hit      = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      op  = lane_op[i*4 +: 4];
      eq  = (lane_data1[i*DATA_W +: DATA_W] == lane_data2[i*DATA_W +: DATA_W]);
      hit = (op == OP_BEQ) ? eq : !eq;
      if (!flush_en && (op == OP_BEQ || op == OP_BNE)) begin
        if (hit) begin
          if (!taken) begin
            taken    = 1'b1;
            win_bid  = lane_bid[i*BID_W +: BID_W];
            win_addr = lane_addr[i*ADDR_W +: ADDR_W];
          end
        end else begin
          retire = retire + RET_W'(1);
        end
      end
    end
  end

  // Fetch advance is the number of valid fetch slots
  always_comb begin
    adv = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      adv = adv + ADDR_W'(fetch_vld[i]);
    end
  end

  assign stall       = iq_full | buffer_full | bid_full;
  assign dispatch_ok = br_dispatch & ~bid_full;

  // Net outstanding-count update, saturating at zero; a taken branch clears everything
  always_comb begin
    up       = SUM_W'(cnt) + SUM_W'(dispatch_ok);
    dn       = SUM_W'(retire);
    cnt_next = '0;
    if (!taken && (up > dn)) begin
      cnt_next = CNT_W'(up - dn);
    end
  end

  // Outstanding counter; bid_full is registered from the next count so it always matches cnt
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      bid_full <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      bid_full <= (cnt_next == CNT_W'(MAX_BR));
    end
  end

  // Fetch pc: redirect, then stall, then advance (wraps naturally)
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= '0;
    end else if (taken) begin
      pc <= win_addr;
    end else if (!stall) begin
      pc <= pc + adv;
    end
  end

  // One-cycle flush pulse to the issue stage; bid holds between flushes
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_en  <= 1'b0;
      flush_bid <= '0;
    end else begin
      flush_en <= taken;
      if (taken) begin
        flush_bid <= win_bid;
      end
    end
  end

  // Buffer flush delay line; reset drops any flush still in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_en <= '0;
      for (int unsigned i = 0; i < FLUSH_DLY; i++) begin
        dly_bid[i] <= '0;
      end
    end else begin
      dly_en[0]  <= flush_en;
      dly_bid[0] <= flush_bid;
      for (int unsigned i = 1; i < FLUSH_DLY; i++) begin
        dly_en[i]  <= dly_en[i-1];
        dly_bid[i] <= dly_bid[i-1];
      end
    end
  end

  assign buffer_flush_en  = dly_en[FLUSH_DLY-1];
  assign buffer_flush_bid = dly_bid[FLUSH_DLY-1];

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_branch_flush_ctrl;

  localparam int LANES     = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int BID_W     = 3;
  localparam int FETCH_W   = 2;
  localparam int FLUSH_DLY = 2;
  localparam int MAX_BR    = 8;

  localparam logic [3:0] BEQ = 4'b1010;
  localparam logic [3:0] BNE = 4'b1011;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [FETCH_W-1:0]      fetch_vld;
  logic                    br_dispatch, iq_full, buffer_full;
  logic [LANES*4-1:0]      lane_op;
  logic [LANES*DATA_W-1:0] lane_data1, lane_data2;
  logic [LANES*BID_W-1:0]  lane_bid;
  logic [LANES*ADDR_W-1:0] lane_addr;
  logic [ADDR_W-1:0]       pc;
  logic                    bid_full, flush_en, buffer_flush_en;
  logic [BID_W-1:0]        flush_bid, buffer_flush_bid;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int m_pc, m_cnt, m_fbid;
  bit m_fe;
  int qe[$];
  int qb[$];

  branch_flush_ctrl #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BID_W(BID_W),
    .FETCH_W(FETCH_W), .FLUSH_DLY(FLUSH_DLY), .MAX_BR(MAX_BR)
  ) dut (
    .clk(clk), .rst(rst), .fetch_vld(fetch_vld), .br_dispatch(br_dispatch),
    .iq_full(iq_full), .buffer_full(buffer_full), .lane_op(lane_op),
    .lane_data1(lane_data1), .lane_data2(lane_data2), .lane_bid(lane_bid),
    .lane_addr(lane_addr), .pc(pc), .bid_full(bid_full), .flush_en(flush_en),
    .flush_bid(flush_bid), .buffer_flush_en(buffer_flush_en),
    .buffer_flush_bid(buffer_flush_bid)
  );

  always #5 clk = ~clk;

  function automatic int exp_bfe();
    return (qe.size() == FLUSH_DLY + 1) ? qe[0] : 0;
  endfunction

  function automatic int exp_bfb();
    return (qb.size() == FLUSH_DLY + 1) ? qb[0] : 0;
  endfunction

  // Next-state of the model from current inputs and model state
  task automatic model_step();
    int nt, wb, wa, sum;
    bit tk, stall, t;
    logic [3:0] op;
    if (!rst) begin
      m_pc = 0; m_cnt = 0; m_fe = 0; m_fbid = 0;
      qe.delete(); qb.delete();
      qe.push_back(0); qb.push_back(0);
      return;
    end
    tk = 0; nt = 0; wb = 0; wa = 0;
    if (!m_fe) begin
      for (int i = 0; i < LANES; i++) begin
        op = lane_op[i*4 +: 4];
        if (op == BEQ || op == BNE) begin
          t = (lane_data1[i*DATA_W +: DATA_W] == lane_data2[i*DATA_W +: DATA_W]);
          if (op == BNE) t = !t;
          if (t && !tk) begin
            tk = 1; wb = int'(lane_bid[i*BID_W +: BID_W]); wa = int'(lane_addr[i*ADDR_W +: ADDR_W]);
          end else if (!t) begin
            nt++;
          end
        end
      end
    end
    stall = iq_full || buffer_full || (m_cnt == MAX_BR);
    if (tk) begin
      m_pc = wa; m_cnt = 0; m_fe = 1; m_fbid = wb;
    end else begin
      m_fe = 0;
      if (!stall) m_pc = (m_pc + $countones(fetch_vld)) % (1 << ADDR_W);
      sum = m_cnt + ((br_dispatch && m_cnt != MAX_BR) ? 1 : 0) - nt;
      m_cnt = (sum < 0) ? 0 : sum;
    end
    qe.push_back(int'(m_fe)); qb.push_back(m_fbid);
    if (qe.size() > FLUSH_DLY + 1) begin
      void'(qe.pop_front()); void'(qb.pop_front());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_vld = '0; br_dispatch = 0; iq_full = 0; buffer_full = 0;
    lane_op = '0; lane_data1 = '0; lane_data2 = '0; lane_bid = '0; lane_addr = '0;
  endtask

  task automatic set_lane(input int i, input logic [3:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [BID_W-1:0] id,
                          input logic [ADDR_W-1:0] ad);
    lane_op[i*4 +: 4]               = op;
    lane_data1[i*DATA_W +: DATA_W]  = a;
    lane_data2[i*DATA_W +: DATA_W]  = b;
    lane_bid[i*BID_W +: BID_W]      = id;
    lane_addr[i*ADDR_W +: ADDR_W]   = ad;
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    fetch_vld = 2'b11; br_dispatch = 1;
    set_lane(0, BEQ, 7, 7, 5, 21);
    tick(); tick();
    checks++; if (pc !== '0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    checks++; if (flush_en !== 1'b0) begin failures++; $display("FAIL reset_flush_en got=%b exp=0", flush_en); end
    checks++; if (flush_bid !== '0) begin failures++; $display("FAIL reset_flush_bid got=%0d exp=0", flush_bid); end
    checks++; if (buffer_flush_en !== 1'b0 || buffer_flush_bid !== '0) begin
      failures++; $display("FAIL reset_buffer got=%b/%0d exp=0/0", buffer_flush_en, buffer_flush_bid); end
    checks++; if (bid_full !== 1'b0) begin failures++; $display("FAIL reset_bid_full got=%b exp=0", bid_full); end
    clear_inputs();
    rst = 1;
  endtask

  task automatic test_pc_advance();
    fetch_vld = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc !== ADDR_W'(2*k)) begin failures++; $display("FAIL pc_advance k=%0d got=%0d exp=%0d", k, pc, 2*k); end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    set_lane(0, BEQ, 0, 0, 1, 30);
    tick();
    checks++; if (pc !== 5'd30 || flush_en !== 1'b1) begin
      failures++; $display("FAIL wrap_setup pc=%0d flush=%b exp pc=30 flush=1", pc, flush_en); end
    clear_inputs();
    fetch_vld = 2'b11;
    tick();
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL wrap_pc got=%0d exp=0", pc); end
    checks++; if (flush_en !== 1'b0) begin failures++; $display("FAIL wrap_pulse got=%b exp=0", flush_en); end
    fetch_vld = 2'b01;
    tick();
    checks++; if (pc !== 5'd1) begin failures++; $display("FAIL wrap_single got=%0d exp=1", pc); end
    clear_inputs();
  endtask

  task automatic test_priority();
    set_lane(0, 4'b0011, $urandom, $urandom, 7, 25);
    set_lane(1, BEQ, 5, 5, 3, 12);
    set_lane(2, 4'b1100, 9, 9, 4, 2);
    set_lane(3, BNE, 1, 2, 6, 20);
    tick();
    checks++; if (flush_en !== 1'b1 || flush_bid !== 3'd3 || pc !== 5'd12) begin
      failures++; $display("FAIL priority got flush=%b bid=%0d pc=%0d exp 1/3/12", flush_en, flush_bid, pc); end
    clear_inputs();
    for (int k = 1; k <= FLUSH_DLY; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (flush_en !== 1'b0) begin failures++; $display("FAIL flush_one_cycle got=%b exp=0", flush_en); end
      end
      if (k < FLUSH_DLY) begin
        checks++; if (buffer_flush_en !== 1'b0) begin failures++; $display("FAIL buf_early k=%0d got=%b exp=0", k, buffer_flush_en); end
      end else begin
        checks++; if (buffer_flush_en !== 1'b1 || buffer_flush_bid !== 3'd3) begin
          failures++; $display("FAIL buf_delay got=%b/%0d exp=1/3", buffer_flush_en, buffer_flush_bid); end
      end
    end
    tick();
    checks++; if (buffer_flush_en !== 1'b0) begin failures++; $display("FAIL buf_one_cycle got=%b exp=0", buffer_flush_en); end
  endtask

  task automatic test_bid_full();
    logic [ADDR_W-1:0] held;
    clear_inputs();
    do_reset();
    fetch_vld = 2'b11; br_dispatch = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (bid_full !== (k == 8)) begin failures++; $display("FAIL fill k=%0d got=%b exp=%0d", k, bid_full, k == 8); end
    end
    held = pc;
    tick();  // dispatch while full is dropped, pc holds
    checks++; if (pc !== held || bid_full !== 1'b1) begin
      failures++; $display("FAIL full_hold pc=%0d full=%b exp pc=%0d full=1", pc, bid_full, held); end
    br_dispatch = 0; fetch_vld = 2'b00;
    set_lane(2, BEQ, 1, 2, 0, 0);
    tick();
    checks++; if (bid_full !== 1'b0) begin failures++; $display("FAIL retire_one got=%b exp=0", bid_full); end
    br_dispatch = 1;
    tick();
    checks++; if (bid_full !== 1'b0) begin failures++; $display("FAIL net_zero got=%b exp=0", bid_full); end
    clear_inputs(); br_dispatch = 1;
    tick();
    checks++; if (bid_full !== 1'b1) begin failures++; $display("FAIL refill got=%b exp=1", bid_full); end
    clear_inputs();
  endtask

  task automatic test_redirect_stall();
    logic [ADDR_W-1:0] exp_pc;
    clear_inputs();
    iq_full = 1; br_dispatch = 1; fetch_vld = 2'b11;
    set_lane(0, BNE, 3, 4, 5, 9);
    tick();
    checks++; if (pc !== 5'd9 || flush_en !== 1'b1 || flush_bid !== 3'd5 || bid_full !== 1'b0) begin
      failures++; $display("FAIL redirect_stall pc=%0d flush=%b bid=%0d full=%b exp 9/1/5/0", pc, flush_en, flush_bid, bid_full); end
    clear_inputs();
    fetch_vld = 2'b01;
    set_lane(0, BEQ, 1, 1, 2, 17);
    set_lane(1, BNE, 1, 2, 4, 3);
    tick();
    checks++; if (flush_en !== 1'b0 || pc !== 5'd10) begin
      failures++; $display("FAIL wrong_path flush=%b pc=%0d exp 0/10", flush_en, pc); end
    clear_inputs();
    for (int i = 0; i < LANES; i++) set_lane(i, BEQ, 1, 2, 0, 0);
    tick();  // counter is 0: excess retires saturate
    clear_inputs(); br_dispatch = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (bid_full !== (k == 8)) begin failures++; $display("FAIL clear_sat k=%0d got=%b exp=%0d", k, bid_full, k == 8); end
    end
    exp_pc = pc;
    clear_inputs();
    do_reset();
    checks++; if (pc !== '0 || bid_full !== 1'b0) begin
      failures++; $display("FAIL rereset pc=%0d full=%b exp 0/0 (prev pc %0d)", pc, bid_full, exp_pc); end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    set_lane(2, BNE, 8, 9, 6, 14);
    tick();
    checks++; if (flush_en !== 1'b1) begin failures++; $display("FAIL midflush_setup got=%b exp=1", flush_en); end
    clear_inputs();
    rst = 0;
    tick();
    checks++; if (pc !== '0 || flush_en !== 1'b0 || flush_bid !== '0 || bid_full !== 1'b0 ||
                  buffer_flush_en !== 1'b0 || buffer_flush_bid !== '0) begin
      failures++; $display("FAIL midflush_zero pc=%0d fe=%b fb=%0d full=%b bfe=%b bfb=%0d exp all 0",
                           pc, flush_en, flush_bid, bid_full, buffer_flush_en, buffer_flush_bid); end
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (buffer_flush_en !== 1'b0) begin failures++; $display("FAIL midflush_cancel k=%0d got=%b exp=0", k, buffer_flush_en); end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    clear_inputs();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 63) != 0);
      fetch_vld   = FETCH_W'($urandom);
      br_dispatch = ($urandom_range(0, 2) != 0);
      iq_full     = ($urandom_range(0, 7) == 0);
      buffer_full = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < LANES; i++) begin
        case ($urandom_range(0, 3))
          0: op = BEQ;
          1: op = BNE;
          default: op = 4'($urandom);
        endcase
        if ($urandom_range(0, 2) == 0) op = 4'b0000;
        set_lane(i, op, $urandom_range(0, 3), $urandom_range(0, 3), BID_W'($urandom), ADDR_W'($urandom));
      end
      tick();
      checks++; if (pc !== ADDR_W'(m_pc)) begin failures++; $display("FAIL rnd_pc n=%0d got=%0d exp=%0d", n, pc, m_pc); end
      checks++; if (flush_en !== m_fe) begin failures++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, flush_en, m_fe); end
      if (m_fe) begin
        checks++; if (flush_bid !== BID_W'(m_fbid)) begin failures++; $display("FAIL rnd_fbid n=%0d got=%0d exp=%0d", n, flush_bid, m_fbid); end
      end
      checks++; if (bid_full !== (m_cnt == MAX_BR)) begin failures++; $display("FAIL rnd_full n=%0d got=%b exp=%0d", n, bid_full, m_cnt == MAX_BR); end
      checks++; if (buffer_flush_en !== 1'(exp_bfe())) begin failures++; $display("FAIL rnd_bfe n=%0d got=%b exp=%0d", n, buffer_flush_en, exp_bfe()); end
      if (exp_bfe() != 0) begin
        checks++; if (buffer_flush_bid !== BID_W'(exp_bfb())) begin failures++; $display("FAIL rnd_bfb n=%0d got=%0d exp=%0d", n, buffer_flush_bid, exp_bfb()); end
      end
    end
    clear_inputs();
    rst = 1;
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_pc_advance();
    test_wrap();
    test_priority();
    test_bid_full();
    test_redirect_stall();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of resolving lanes from the register file.
REQ-002 Parameter DATA_W, default 32, operand width.
REQ-003 Parameter ADDR_W, default 5, PC and branch-target width.
REQ-004 Parameter BID_W, default 3, branch-id width.
REQ-005 Parameter FETCH_W, default 2, instructions fetched per cycle.
REQ-006 Parameter FLUSH_DLY, default 1 (range 1-4), cycles from flush_en to buffer_flush_en.
REQ-007 Parameter MAX_BR, default 2**BID_W, maximum outstanding branches.
REQ-008 clk  in  1  sole clock, all state on rising edge.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 fetch_vld  in  FETCH_W  per-slot valid of instructions fetched this cycle.
REQ-011 br_dispatch  in  1  one branch issued this cycle; allocates an outstanding slot.
REQ-012 iq_full, buffer_full  in  1 each  downstream stall sources.
REQ-013 lane_op  in  LANES*4  per-lane opcode.
REQ-014 lane_data1, lane_data2  in  LANES*DATA_W each  per-lane compare operands.
REQ-015 lane_bid  in  LANES*BID_W  per-lane branch id.
REQ-016 lane_addr  in  LANES*ADDR_W  per-lane branch target.
REQ-017 pc  out  ADDR_W  fetch address.
REQ-018 bid_full  out  1  outstanding count equals MAX_BR.
REQ-019 flush_en  out  1  one-cycle flush pulse to the issue stage.
REQ-020 flush_bid  out  BID_W  id of the taken branch.
REQ-021 buffer_flush_en  out  1  flush_en delayed FLUSH_DLY cycles.
REQ-022 buffer_flush_bid  out  BID_W  flush_bid delayed FLUSH_DLY cycles.

Function
REQ-023 Branch opcodes: 4'b1010 BEQ (taken if data1==data2), 4'b1011 BNE (taken if data1!=data2); every other opcode is a non-branch and is ignored.
REQ-024 A lane resolves when its op is BEQ or BNE; a resolving lane is taken or not-taken per REQ-023.
REQ-025 When several lanes are taken in one cycle, the lowest-index lane wins; the other lanes are discarded.
REQ-026 Winner in cycle N shall drive flush_en=1, flush_bid=winner bid, and pc=winner addr in cycle N+1 (one-cycle registered latency).
REQ-027 flush_en shall be high for exactly one cycle per taken event.
REQ-028 During any cycle where flush_en=1, lane inputs are wrong-path and shall be ignored: no flush, no retire.
REQ-029 stall = iq_full | buffer_full | bid_full.
REQ-030 With no redirect and no stall, pc shall advance by popcount(fetch_vld), modulo 2**ADDR_W (wrap without error).
REQ-031 With stall and no redirect, pc shall hold.
REQ-032 Priority for the pc update: redirect, then stall, then advance.
REQ-033 Outstanding counter, width clog2(MAX_BR+1): +1 on br_dispatch when not full, -1 per not-taken resolving lane; simultaneous events apply the net change in one cycle.
REQ-034 br_dispatch while bid_full=1 shall be dropped (counter unchanged).
REQ-035 Counter saturates at 0: excess retires are ignored.
REQ-036 On a taken event the counter shall be cleared to 0 at the same edge that asserts flush_en; a same-cycle br_dispatch is discarded.
REQ-037 bid_full shall be registered from the counter: 1 when count==MAX_BR.
REQ-038 The buffer flush path is a FLUSH_DLY-stage shift register of {flush_en, flush_bid}; back-to-back flushes shall be preserved in order.

Reset
REQ-039 While rst=0 at a clock edge: pc=0, flush_en=0, flush_bid=0, buffer_flush_en=0, buffer_flush_bid=0, counter=0, bid_full=0, delay stages cleared.
REQ-040 Reset asserted mid-flush shall cancel any pending buffer_flush_en in the delay line.
REQ-041 The first pc update after reset release shall follow the normal rules from pc=0.

Verification
REQ-042 Reset, fetch_vld=2'b11 for 3 cycles, no stall -> pc 0,2,4,6.
REQ-043 pc=30, fetch_vld=2'b11 -> pc=0 (wrap); fetch_vld=2'b01 -> pc=1.
REQ-044 Lane1 BEQ 5==5 addr=12 bid=3, lane3 BNE 1!=2 addr=20 bid=6 in the same cycle -> next cycle flush_en=1, flush_bid=3, pc=12; buffer_flush_en=1 with bid 3 exactly FLUSH_DLY cycles later.
REQ-045 Eight br_dispatch pulses -> bid_full=1 and pc holds; then one not-taken BEQ -> count 7, bid_full=0; simultaneous dispatch plus not-taken retire -> count unchanged.
REQ-046 Taken branch with iq_full=1 -> pc=target (redirect beats stall) and counter=0; lanes taken during the flush_en cycle -> no second flush.
REQ-047 rst=0 on the cycle after flush_en with FLUSH_DLY=2 -> buffer_flush_en never asserts; all outputs are 0.
